// File: rtl/core_mem_responder.sv
// Serialises core fetch/data requests onto one backing-memory port, data op first, stalling the core until both respond.
// Minimum stall is 2 cycles per op; ready/response waits add 1 cycle each, and mem_req_* hold steady under backpressure.
module core_mem_responder #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [AWIDTH-1:0]   icache_addr,
  input  logic                icache_re,
  output logic [DWIDTH-1:0]   icache_dout,
  input  logic [AWIDTH-1:0]   dcache_addr,
  input  logic                dcache_re,
  input  logic [DWIDTH/8-1:0] dcache_we,
  input  logic [DWIDTH-1:0]   dcache_din,
  output logic [DWIDTH-1:0]   dcache_dout,
  output logic                stall,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [AWIDTH-1:0]   mem_req_addr,
  output logic [DWIDTH/8-1:0] mem_req_we,
  output logic [DWIDTH-1:0]   mem_req_data,
  input  logic                mem_resp_valid,
  input  logic [DWIDTH-1:0]   mem_resp_data,
  output logic [31:0]         perf_stall_cycles
);

  localparam int BW = DWIDTH / 8;

  typedef enum logic [2:0] {IDLE, D_REQ, D_RESP, I_REQ, I_RESP} state_t;

  state_t              state;
  logic [AWIDTH-3:0]   d_word;
  logic [AWIDTH-3:0]   i_word;
  logic [BW-1:0]       d_we;
  logic [DWIDTH-1:0]   d_din;
  logic                i_pend;
  logic                data_op;
  logic                unused_addr_bits;

  assign data_op = (dcache_we != '0) || dcache_re;
  // Memory is word addressed; the byte offset is carried by the write mask.
  assign unused_addr_bits = ^{icache_addr[1:0], dcache_addr[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      d_word            <= '0;
      i_word            <= '0;
      d_we              <= '0;
      d_din             <= '0;
      i_pend            <= 1'b0;
      icache_dout       <= '0;
      dcache_dout       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (state != IDLE) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      case (state)
        IDLE: begin
          d_word <= dcache_addr[AWIDTH-1:2];
          i_word <= icache_addr[AWIDTH-1:2];
          d_we   <= dcache_we;
          d_din  <= dcache_din;
          i_pend <= icache_re;
          if (data_op)        state <= D_REQ;
          else if (icache_re) state <= I_REQ;
        end
        D_REQ: if (mem_req_ready) state <= D_RESP;
        D_RESP: begin
          if (mem_resp_valid) begin
            if (d_we == '0) dcache_dout <= mem_resp_data;
            state <= i_pend ? I_REQ : IDLE;
          end
        end
        I_REQ: if (mem_req_ready) state <= I_RESP;
        I_RESP: begin
          if (mem_resp_valid) begin
            icache_dout <= mem_resp_data;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything below decodes registered state only, so core inputs never reach stall or mem_req_*.
  assign stall         = (state != IDLE);
  assign mem_req_valid = (state == D_REQ) || (state == I_REQ);
  assign mem_req_addr  = (state == I_REQ) ? {i_word, 2'b00} : {d_word, 2'b00};
  assign mem_req_we    = (state == D_REQ) ? d_we : '0;
  assign mem_req_data  = d_din;

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: transaction-level model plus reactive backing memory, checked every cycle.
module tb_core_mem_responder;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } req_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] icache_addr = '0;
  logic        icache_re = 1'b0;
  logic [31:0] icache_dout;
  logic [31:0] dcache_addr = '0;
  logic        dcache_re = 1'b0;
  logic [3:0]  dcache_we = '0;
  logic [31:0] dcache_din = '0;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_we;
  logic [31:0] mem_req_data;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [31:0] perf_stall_cycles;

  core_mem_responder #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .icache_addr(icache_addr), .icache_re(icache_re), .icache_dout(icache_dout),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
    .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Default memory image; one word holds a NOP-like instruction for the fetch tests.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h1000_0004) return 32'h0000_0013;
    return a ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  // Driver-owned knobs and request counters.
  int cfg_rw = 0;      // ready-wait cycles for the first request of a transaction
  int cfg_sw = 0;      // response-wait cycles for every request
  int spur_cnt = 0;
  int preset_req = 0;

  // ---------------- behavioural model ----------------
  logic [31:0] mmem [logic [31:0]];
  int          m_cnt = 0, m_k = 0, m_ld = 0, m_n = 0, m_rwd = 0, m_rwf = 0;
  logic        m_dop = 0, m_dread = 0, m_fetch = 0;
  logic [31:0] m_dval = 0, m_ival = 0;
  req_t        m_dreq, m_ireq, exp_req;
  logic        exp_stall = 0, exp_valid = 0;
  logic [31:0] exp_perf = 0, exp_icache = 0, exp_dcache = 0;
  int          preset_seen = 0;

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return mmem.exists(w) ? mmem[w] : init_word(w);
  endfunction

  initial forever begin
    logic in_d, in_f;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_cnt = 0; m_k = 0; exp_perf = 0; exp_icache = 0; exp_dcache = 0;
      exp_stall = 0; exp_valid = 0;
    end else begin
      if (preset_req != preset_seen) begin
        preset_seen = preset_req;
        exp_perf = 32'hFFFF_FFFE;
      end
      if (m_cnt == 0) begin
        m_dop   = (dcache_we != 4'b0) || dcache_re;
        m_fetch = icache_re;
        if (m_dop || m_fetch) begin
          m_rwd = m_dop ? cfg_rw : 0;
          m_rwf = m_dop ? 0 : cfg_rw;
          m_ld  = m_dop ? 2 + m_rwd + cfg_sw : 0;
          m_n   = m_ld + (m_fetch ? 2 + m_rwf + cfg_sw : 0);
          m_cnt = m_n;
          m_k   = 1;
          m_dread = (dcache_we == 4'b0);
          m_dreq  = '{addr: {dcache_addr[31:2], 2'b00}, we: dcache_we, data: dcache_din};
          m_ireq  = '{addr: {icache_addr[31:2], 2'b00}, we: 4'b0, data: 32'h0};
          if (m_dop) begin
            if (m_dread) m_dval = m_rd(dcache_addr);
            else mmem[m_dreq.addr] = merge(m_rd(dcache_addr), dcache_din, dcache_we);
          end
          if (m_fetch) m_ival = m_rd(icache_addr);
        end
      end else begin
        exp_perf = exp_perf + 32'd1;
        if (m_dop && m_dread && m_k == m_ld) exp_dcache = m_dval;
        if (m_fetch && m_k == m_n) exp_icache = m_ival;
        m_cnt--;
        m_k++;
      end
      exp_stall = (m_cnt != 0);
      in_d = (m_cnt != 0) && m_dop && (m_k <= 1 + m_rwd);
      in_f = (m_cnt != 0) && m_fetch && (m_k >= m_ld + 1) && (m_k <= m_ld + 1 + m_rwf);
      exp_valid = in_d || in_f;
      exp_req   = in_d ? m_dreq : m_ireq;
    end
  end

  // ---------------- reactive backing memory ----------------
  logic [31:0] rmem [logic [31:0]];
  req_t        rlog [$];
  int          spur_seen = 0, r_wcnt = 0, r_rcnt = 0;
  logic        r_acc = 0, r_busy = 0, r_first = 1;
  req_t        r_cur;

  initial begin
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    forever begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      if (!reset_n) begin
        r_acc = 0; r_busy = 0; r_wcnt = 0; r_first = 1;
      end else if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hFFFF_FFFF;
      end else begin
        if (!stall) r_first = 1;
        if (r_acc) begin
          r_acc = 0; r_busy = 1; r_rcnt = cfg_sw;
        end
        if (r_busy) begin
          if (r_rcnt == 0) begin
            r_busy = 0;
            mem_resp_valid = 1'b1;
            if (r_cur.we != 4'b0) begin
              rmem[r_cur.addr] = merge(rmem.exists(r_cur.addr) ? rmem[r_cur.addr]
                                       : init_word(r_cur.addr), r_cur.data, r_cur.we);
              mem_resp_data = 32'hCAFE_F00D;
            end else begin
              mem_resp_data = rmem.exists(r_cur.addr) ? rmem[r_cur.addr] : init_word(r_cur.addr);
            end
          end else r_rcnt--;
        end else if (mem_req_valid) begin
          if (r_wcnt >= (r_first ? cfg_rw : 0)) begin
            mem_req_ready = 1'b1;
            r_acc = 1; r_first = 0; r_wcnt = 0;
            r_cur = '{addr: mem_req_addr, we: mem_req_we, data: mem_req_data};
            rlog.push_back(r_cur);
          end else r_wcnt++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (reset_n === 1'b1) begin
      chk("stall", {31'b0, stall}, {31'b0, exp_stall});
      chk("perf_stall_cycles", perf_stall_cycles, exp_perf);
      chk("icache_dout", icache_dout, exp_icache);
      chk("dcache_dout", dcache_dout, exp_dcache);
      chk("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        chk("mem_req_addr", mem_req_addr, exp_req.addr);
        chk("mem_req_we", {28'b0, mem_req_we}, {28'b0, exp_req.we});
        if (exp_req.we != 4'b0) chk("mem_req_data", mem_req_data, exp_req.data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_core(input logic [31:0] ia, input logic ire, input logic [31:0] da,
                          input logic dre, input logic [3:0] dwe, input logic [31:0] dd);
    icache_addr = ia; icache_re = ire; dcache_addr = da;
    dcache_re = dre; dcache_we = dwe; dcache_din = dd;
  endtask

  task automatic txn(input logic [31:0] ia, input logic ire, input logic [31:0] da,
                     input logic dre, input logic [3:0] dwe, input logic [31:0] dd,
                     input logic junk, output int ncyc);
    @(negedge clk);
    set_core(ia, ire, da, dre, dwe, dd);
    @(posedge clk);
    ncyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) break;
      ncyc++;
      if (junk) set_core($urandom, 1'b1, $urandom, 1'b1, 4'($urandom), $urandom);
      else      set_core('0, 1'b0, '0, 1'b0, 4'b0, '0);
    end
    set_core('0, 1'b0, '0, 1'b0, 4'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("reset_perf", perf_stall_cycles, 32'd0);
    chk("reset_icache", icache_dout, 32'd0);

    // Fetch only, unaligned address.
    txn(32'h1000_0006, 1'b1, 32'h0, 1'b0, 4'b0, 32'h0, 1'b0, n);
    chk("fetch_stall_cycles", n, 2);
    chk("fetch_nreq", rlog.size(), 1);
    chk("fetch_req_addr", rlog[0].addr, 32'h1000_0004);
    chk("fetch_req_we", {28'b0, rlog[0].we}, 32'd0);
    chk("fetch_icache", icache_dout, 32'h0000_0013);
    chk("fetch_perf", perf_stall_cycles, 32'd2);

    // Store then fetch from the same word: fetch must observe the store.
    txn(32'h8000_0010, 1'b1, 32'h8000_0010, 1'b0, 4'b0011, 32'hDEAD_BEEF, 1'b0, n);
    chk("store_stall_cycles", n, 4);
    chk("store_nreq", rlog.size(), 3);
    chk("store_req_we", {28'b0, rlog[1].we}, 32'h3);
    chk("store_req_data", rlog[1].data, 32'hDEAD_BEEF);
    chk("store_then_fetch_we", {28'b0, rlog[2].we}, 32'd0);
    chk("store_fetch_icache", icache_dout, 32'hDA5A_BEEF);
    chk("store_dcache_hold", dcache_dout, 32'd0);

    // Plain load.
    txn(32'h0, 1'b0, 32'h0000_0100, 1'b1, 4'b0, 32'h0, 1'b0, n);
    chk("load_stall_cycles", n, 2);
    chk("load_dcache", dcache_dout, 32'h5A5A_1334);
    chk("load_icache_hold", icache_dout, 32'hDA5A_BEEF);

    // Backpressure: 3 ready-wait cycles on the data request, junk core inputs while stalled.
    cfg_rw = 3;
    txn(32'h1000_0006, 1'b1, 32'h0000_0202, 1'b1, 4'b0, 32'h0, 1'b1, n);
    cfg_rw = 0;
    chk("bp_stall_cycles", n, 7);
    chk("bp_nreq", rlog.size(), 6);
    chk("bp_data_addr", rlog[4].addr, 32'h0000_0200);
    chk("bp_dcache", dcache_dout, 32'h5A5A_1034);
    chk("bp_icache", icache_dout, 32'h0000_0013);

    // Spurious response in IDLE.
    @(negedge clk);
    spur_cnt++;
    repeat (3) @(negedge clk);
    chk("spur_icache", icache_dout, 32'h0000_0013);
    chk("spur_dcache", dcache_dout, 32'h5A5A_1034);
    chk("spur_stall", {31'b0, stall}, 32'd0);

    // Reset in the middle of a slow data response.
    cfg_sw = 5;
    @(negedge clk);
    set_core('0, 1'b0, 32'h0000_0300, 1'b1, 4'b0, '0);
    @(posedge clk);
    @(negedge clk);
    set_core('0, 1'b0, '0, 1'b0, 4'b0, '0);
    repeat (2) @(negedge clk);
    chk("pre_reset_stall", {31'b0, stall}, 32'd1);
    chk("pre_reset_valid", {31'b0, mem_req_valid}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_stall", {31'b0, stall}, 32'd0);
    chk("arst_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("arst_we", {28'b0, mem_req_we}, 32'd0);
    chk("arst_icache", icache_dout, 32'd0);
    chk("arst_dcache", dcache_dout, 32'd0);
    chk("arst_perf", perf_stall_cycles, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    cfg_sw = 0;
    @(negedge clk);
    spur_cnt++;
    repeat (3) @(negedge clk);
    chk("late_resp_dcache", dcache_dout, 32'd0);
    chk("late_resp_stall", {31'b0, stall}, 32'd0);

    // Counter wrap.
    @(negedge clk);
    #2 force dut.perf_stall_cycles = 32'hFFFF_FFFE;
    preset_req++;
    @(negedge clk);
    #2 release dut.perf_stall_cycles;
    txn(32'h1000_0004, 1'b1, 32'h0, 1'b0, 4'b0, 32'h0, 1'b0, n);
    chk("wrap_stall_cycles", n, 2);
    chk("wrap_perf", perf_stall_cycles, 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mem_responder.md
# core_mem_responder

Memory-side responder for the Riscv151 core's instruction and data memory ports. It samples the core's icache/dcache requests, serialises them onto a single-ported backing-memory request/response channel, holds `stall` high until both responses return, then presents registered read data to the core. Read data follows synchronous-read semantics: data for a request sampled at a clock edge is valid in the cycle `stall` next reads low.

## Interface

Parameters:
- `AWIDTH`, 32: byte address width.
- `DWIDTH`, 32: data word width; byte-mask width is `DWIDTH/8`.

Ports:
- `clk` input 1: the single clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `icache_addr` input AWIDTH: instruction fetch byte address.
- `icache_re` input 1: fetch request enable.
- `icache_dout` output DWIDTH: fetched instruction word.
- `dcache_addr` input AWIDTH: data byte address.
- `dcache_re` input 1: data read enable.
- `dcache_we` input DWIDTH/8: byte write mask. Nonzero means a store.
- `dcache_din` input DWIDTH: store data, already lane-aligned by the core.
- `dcache_dout` output DWIDTH: load data, full word, unmasked.
- `stall` output 1: core must hold all state while high.
- `mem_req_valid` output 1: backing-memory request valid.
- `mem_req_ready` input 1: backing memory accepts the request.
- `mem_req_addr` output AWIDTH: word-aligned address, `{addr[AWIDTH-1:2],2'b00}`.
- `mem_req_we` output DWIDTH/8: byte mask. 0 means read.
- `mem_req_data` output DWIDTH: write data.
- `mem_resp_valid` input 1: response or write acknowledge; one per accepted request, in order.
- `mem_resp_data` input DWIDTH: read data; ignored on writes.
- `perf_stall_cycles` output 32: count of cycles with `stall` high.

## Operation

Requests are sampled only at an edge where `stall` is low (state IDLE):
- Data op pending: `dcache_we != 0`, or `dcache_re` is high.
- Fetch pending: `icache_re` is high.
- On the sample edge, latch addr/we/din and both pending flags.

FSM states: IDLE, D_REQ, D_RESP, I_REQ, I_RESP.
- IDLE: if the data flag is set, go to D_REQ. Otherwise, if the fetch flag is set, go to I_REQ. Otherwise stay in IDLE.
- D_REQ: drive `mem_req_valid` with the latched data op. On `mem_req_ready`, go to D_RESP.
- D_RESP: on `mem_resp_valid`:
  - For a read, load `dcache_dout` from `mem_resp_data`.
  - For a write, leave `dcache_dout` unchanged.
  - Then go to I_REQ if the fetch flag is set, else IDLE.
- I_REQ: drive a read at the latched fetch address. On `mem_req_ready`, go to I_RESP.
- I_RESP: on `mem_resp_valid`, load `icache_dout`, then go to IDLE.

Ordering and priority:
- The data op is always issued before the fetch, so a store is visible to a fetch sampled in the same cycle.
- Priority is fixed (data first); no fairness counter.

Outputs by state:
- `stall` = (state != IDLE), decoded directly from the state register.
- `mem_req_valid` is high only in D_REQ and I_REQ.
- `mem_req_*` are held stable while valid and not ready.

Ignored inputs:
- `mem_resp_valid` arriving outside D_RESP/I_RESP is ignored and does not change outputs.
- Core inputs are ignored while `stall` is high.

Counter: `perf_stall_cycles` increments by 1 on every edge where `stall` is high and wraps at 2^32 to 0.

Reset: `reset_n` low forces the following immediately and asynchronously, including mid-transaction:
- state to IDLE;
- `stall`, `mem_req_valid`, `mem_req_we` to 0;
- `icache_dout`, `dcache_dout`, `perf_stall_cycles`, and all latches to 0.

A response for a request abandoned by reset is dropped. The backing memory must be reset concurrently.

## Timing

- Sample edge E0 (IDLE). `stall` is high in the cycle after E0 whenever any flag is set.
- Minimum latency with ready always high and a 1-cycle response:
  - fetch only: 2 stall cycles;
  - data + fetch: 4 stall cycles.
- Each extra ready-wait cycle or response-wait cycle adds 1 stall cycle.
- `mem_req_valid` can be asserted no earlier than one cycle after E0. There is no combinational path from core inputs to `mem_req_*` or to `stall`.
- Both `dout`s update at the response edge and stay constant until the next response of the same kind.
- `stall` falls in the cycle after the final response edge. That cycle is IDLE, and the core's next request is sampled at its closing edge.
- No flags set: `stall` stays low, no memory traffic, and `dout`s hold.

## Test plan

- **Reset:** assert `reset_n`=0 mid D_RESP. Outputs are immediately 0 and state is IDLE. A late `mem_resp_valid` leaves `dcache_dout`=0.
- **Fetch only:** `icache_addr`=0x1000_0006, `icache_re`=1, `dcache_re`=0, `dcache_we`=0.
  - Memory sees `mem_req_addr`=0x1000_0004, `mem_req_we`=0.
  - Response 0x0000_0013 gives `icache_dout`=0x0000_0013 and 2 stall cycles.
  - `perf_stall_cycles`=2.
- **Store then fetch:** `dcache_we`=4'b0011, `dcache_addr`=0x8000_0010, `dcache_din`=0xDEAD_BEEF, plus a fetch.
  - Write is issued first with mask 0011 and data 0xDEAD_BEEF, then the fetch read.
  - `dcache_dout` is unchanged.
  - 4 stall cycles.
- **Backpressure:** hold `mem_req_ready`=0 for 3 cycles during D_REQ.
  - `mem_req_*` stay stable.
  - `stall` lasts 7 cycles total.
  - Core input changes during the stall have no effect.
- **Spurious response:** pulse `mem_resp_valid` with data 0xFFFF_FFFF in IDLE. Both `dout`s and the state are unchanged.
- **Counter wrap:** force `perf_stall_cycles` near wrap (or run 2^32 stall cycles in a fast model). It rolls from 0xFFFF_FFFF to 0x0000_0000.
